// File: rtl/board_step_engine.sv
// Board register for the 1-D cellular automaton game: load, step, lose detect,
// and a valid/ready serializer that dumps a board snapshot MSB first.
module board_step_engine #(
    parameter int unsigned       WIDTH = 16,
    parameter logic [WIDTH-1:0]  SEED  = 16'h0080,
    parameter logic [7:0]        RULE  = 8'd90
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             loadData,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             readData,
    input  logic             writeout,
    output logic [WIDTH-1:0] board,
    output logic [8:0]       gen_count,
    output logic             loseSig,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    ser_state_t       state;
    logic [WIDTH-1:0] shift_reg;
    logic [IW-1:0]    bit_idx;
    logic             wr_q;
    logic             wr_edge;
    logic [WIDTH-1:0] next_board;
    logic [2:0]       nbhd;

    // Neighbourhood is {left, self, right}; left is the higher index, wrapping.
    always_comb begin
        next_board = '0;
        nbhd       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nbhd = {board[(i + 1) % WIDTH],
                    board[i],
                    board[(i + WIDTH - 1) % WIDTH]};
            next_board[i] = RULE[nbhd];
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            board     <= SEED;
            gen_count <= '0;
            loseSig   <= 1'b0;
        end else if (restart) begin
            board     <= SEED;
            gen_count <= '0;
            loseSig   <= 1'b0;
        end else if (loadData) begin
            board     <= seed_in;
            gen_count <= '0;
            loseSig   <= 1'b0;
        end else if (readData) begin
            board <= next_board;
            if (gen_count != 9'h1FF) begin
                gen_count <= gen_count + 9'd1;
            end
            if (next_board == '0) begin
                loseSig <= 1'b1;
            end
        end
    end

    assign wr_edge = writeout && !wr_q;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            wr_q      <= 1'b0;
        end else begin
            wr_q <= writeout;
            if (restart) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (wr_edge) begin
                            shift_reg <= board;
                            bit_idx   <= LAST_IDX;
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (ser_ready) begin
                            shift_reg <= shift_reg << 1;
                            bit_idx   <= bit_idx - 1'b1;
                            if (bit_idx == '0) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ser_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign ser_data  = ser_valid && shift_reg[WIDTH-1];
    assign ser_last  = ser_valid && (bit_idx == '0);

endmodule

// File: doc/board_step_engine.md
Name: board_step_engine

Overview:
- Datapath stage directly downstream of the game control FSM.
- Holds the game board as a 1-D cellular-automaton register and loads it on loadData/restart.
- Advances one generation per cycle while readData is high, raises loseSig back to the FSM when the board dies, and serializes a board snapshot to the display when writeout is asserted.

Parameters:
- WIDTH, 16, number of cells; board bit i is cell i; cells wrap around.
- SEED, 16'h0080, board value after reset or restart; WIDTH bits.
- RULE, 8'd90, elementary CA rule table indexed by {left, self, right}.

Ports:
- clka  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- restart  input  1  reload SEED and clear status; from FSM.
- loadData  input  1  load seed_in into the board; from FSM.
- seed_in  input  WIDTH  external seed pattern.
- readData  input  1  step enable, one generation per cycle while high.
- writeout  input  1  request a serial dump of the board; rising-edge detected.
- board  output  WIDTH  current board register.
- gen_count  output  9  generations stepped since the last load; saturates at 511.
- loseSig  output  1  sticky: board became all-zero after a step.
- ser_data  output  1  serial board bit, MSB (cell WIDTH-1) first.
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  display accepts the bit when ser_valid && ser_ready.
- ser_last  output  1  high with the final bit (cell 0).
- busy  output  1  serializer active.

Behaviour:
- Clock and reset:
  - One clock, clka. Reset rst_n is asynchronous and active-low.
  - Reset values: board=SEED, gen_count=0, loseSig=0, ser_valid=0, ser_last=0, ser_data=0, busy=0. Serializer state=IDLE; writeout edge register=0.
- Board update priority, per cycle: restart > loadData > readData > hold.
  - restart: board<=SEED, gen_count<=0, loseSig<=0. Also aborts serialization: next cycle ser_valid=0, busy=0, state=IDLE.
  - loadData: board<=seed_in, gen_count<=0, loseSig<=0. Does not affect the serializer.
  - readData: board[i] <= RULE[{board[(i+1)%WIDTH], board[i], board[(i-1+WIDTH)%WIDTH}].
    - gen_count <= gen_count+1, saturating at 9'h1FF.
    - The new board is visible the cycle after readData is sampled.
- loseSig:
  - Set in the same edge that writes an all-zero board via a readData step.
  - Stays set until restart or loadData.
  - Loading an all-zero seed does not set it; the first subsequent step does.
- Serializer FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT on a writeout rising edge (writeout=1 now and 0 in the previous cycle). Snapshot board into shift_reg and set bit_idx=WIDTH-1.
  - Next cycle after the edge: ser_valid=1, ser_data=shift_reg[WIDTH-1], busy=1.
  - A transfer occurs on ser_valid && ser_ready: shift left, decrement bit_idx.
  - ser_last = ser_valid && (bit_idx==0).
  - Transfer with ser_last -> IDLE; ser_valid=0 next cycle.
  - ser_ready low: ser_data and ser_last hold stable.
  - Writeout edges during SHIFT are ignored and not queued. A held-high writeout does not retrigger.
  - Board stepping and loading during SHIFT do not disturb the snapshot.
- Simultaneous events:
  - restart with writeout edge: restart wins; no dump starts.
  - loadData with readData: load wins; no step that cycle.
- Reset mid-serialization: outputs go to reset values immediately (asynchronous).

Test Plan:
- Reset with defaults -> board=16'h0080, gen_count=0, loseSig=0, ser_valid=0, busy=0.
- readData high 1 cycle from 16'h0080 -> board=16'h0140, gen_count=1. Second step -> 16'h0220.
- loadData, seed_in=16'h0001, then 1 step -> board=16'h8002 (wrap-around both edges).
- loadData seed_in=16'h0000 -> loseSig=0. One step -> board=0, loseSig=1. Stays 1 over 3 further steps. loadData 16'h0010 -> loseSig=0.
- board=16'hA5C3, writeout pulse, ser_ready=1 -> 16 transfers carrying 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. ser_last only on the 16th, then ser_valid=0, busy=0. Drop ser_ready for 3 cycles mid-stream -> bit held, no loss. A second writeout pulse during the dump is ignored.
- Stepping 520 cycles -> gen_count=511 (saturated). restart during SHIFT -> board=SEED, gen_count=0, ser_valid=0 the next cycle.
